// File: rtl/servo_pkg.sv
// Shared types, default limits and the width clamp used by the servo motion controller.
// Build option: SLEW_LIMIT_EN (see servo_slew_step / servo_motion_ctrl).
package servo_pkg;

    typedef logic [15:0] width_t;

    localparam int unsigned SERVO_MIN_US    = 32'd1000;
    localparam int unsigned SERVO_MAX_US    = 32'd2000;
    localparam int unsigned SERVO_CENTER_US = 32'd1500;
    localparam int unsigned SERVO_CLK_HZ    = 32'd50_000_000;

    function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
        width_t r;
        if (w < lo) begin
            r = lo;
        end else if (w > hi) begin
            r = hi;
        end else begin
            r = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_slew_step.sv
// One channel: target/width/settled registers and the per-tick step toward the target.
// With SLEW_LIMIT_EN defined the width moves at most STEP_US per tick; otherwise it jumps to the target.
module servo_slew_step
    import servo_pkg::*;
#(
    parameter int unsigned STEP_US   = 32'd10,
    parameter int unsigned CENTER_US = SERVO_CENTER_US
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  width_t load_width,
    input  logic   step_en,
    output width_t width,
    output logic   settled
);

`ifdef SLEW_LIMIT_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    width_t             target_r;
    width_t             width_r;
    logic               settled_r;
    logic signed [16:0] diff_s;
    logic        [16:0] mag_s;
    width_t             stepped_s;
    width_t             next_width_s;

    // Next width: 17-bit signed difference so neither direction can wrap.
    always_comb begin
        diff_s = $signed({1'b0, target_r}) - $signed({1'b0, width_r});
        if (diff_s < 17'sd0) begin
            mag_s = unsigned'(-diff_s);
        end else begin
            mag_s = unsigned'(diff_s);
        end
        if (diff_s > 17'sd0) begin
            stepped_s = width_r + 16'(STEP_US);
        end else begin
            stepped_s = width_r - 16'(STEP_US);
        end
        if (SLEW_ON && (mag_s > 17'(STEP_US))) begin
            next_width_s = stepped_s;
        end else begin
            next_width_s = target_r;
        end
    end

    // Channel state; the step always sees the target from before a same-edge load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r  <= 16'(CENTER_US);
            width_r   <= 16'(CENTER_US);
            settled_r <= 1'b1;
        end else begin
            if (load) begin
                target_r <= load_width;
            end
            if (step_en) begin
                width_r <= next_width_s;
            end
            settled_r <= (width_r == target_r);
        end
    end

    assign width   = width_r;
    assign settled = settled_r;

endmodule

// File: rtl/servo_motion_ctrl.sv
// Slew-rate controller for a bank of servo channels: command handshake, tick divider, per-channel ramps.
// Build option: SLEW_LIMIT_EN enables bounded stepping; without it each tick jumps straight to the target.
module servo_motion_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH    = 32'd5,
    parameter int unsigned TICK_DIV  = 32'd250000,
    parameter int unsigned STEP_US   = 32'd10,
    parameter int unsigned MIN_US    = SERVO_MIN_US,
    parameter int unsigned MAX_US    = SERVO_MAX_US,
    parameter int unsigned CENTER_US = SERVO_CENTER_US
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_chan,
    input  logic [15:0]             cmd_width,
    input  logic                    hold,
    output logic [NUM_CH-1:0][15:0] width_us,
    output logic [NUM_CH-1:0]       settled,
    output logic                    all_settled,
    output logic                    tick_out,
    output logic                    cmd_err
);

    localparam int unsigned CNT_W = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;

    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              tick_r;
    logic              ready_r;
    logic              err_r;
    logic              accept_s;
    logic              chan_bad_s;
    logic              step_en_s;
    width_t            clamped_s;
    logic [NUM_CH-1:0] load_s;

    // Handshake decode, clamp and divider next-state.
    always_comb begin
        accept_s   = cmd_valid && ready_r;
        chan_bad_s = ({1'b0, cmd_chan} >= 4'(NUM_CH));
        clamped_s  = clamp_width(cmd_width, 16'(MIN_US), 16'(MAX_US));
        step_en_s  = tick_r && !hold;
        if (cnt_r == CNT_W'(TICK_DIV - 32'd1)) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
        for (int i = 0; i < int'(NUM_CH); i++) begin
            load_s[i] = accept_s && !chan_bad_s && (cmd_chan == 3'(i));
        end
    end

    // Free-running divider; tick is registered so it is high while the count sits at TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            tick_r  <= 1'b0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            tick_r  <= (cnt_next_s == CNT_W'(TICK_DIV - 32'd1));
            ready_r <= 1'b1;
            err_r   <= accept_s && chan_bad_s;
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        servo_slew_step #(
            .STEP_US   (STEP_US),
            .CENTER_US (CENTER_US)
        ) u_step (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load_s[g]),
            .load_width (clamped_s),
            .step_en    (step_en_s),
            .width      (width_us[g]),
            .settled    (settled[g])
        );
    end

    assign cmd_ready   = ready_r;
    assign tick_out    = tick_r;
    assign cmd_err     = err_r;
    assign all_settled = &settled;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Self-checking bench for servo_motion_ctrl: cycle model feeds a scoreboard queue, plus directed checks.
module tb_servo_motion_ctrl;

    localparam int NUM_CH    = 5;
    localparam int TICK_DIV  = 4;
    localparam int STEP_US   = 10;
    localparam int MIN_US    = 1000;
    localparam int MAX_US    = 2000;
    localparam int CENTER_US = 1500;
`ifdef SLEW_LIMIT_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [2:0]              cmd_chan;
    logic [15:0]             cmd_width;
    logic                    hold;
    logic [NUM_CH-1:0][15:0] width_us;
    logic [NUM_CH-1:0]       settled;
    logic                    all_settled;
    logic                    tick_out;
    logic                    cmd_err;

    always #5 clk = ~clk;

    servo_motion_ctrl #(
        .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .STEP_US(STEP_US),
        .MIN_US(MIN_US), .MAX_US(MAX_US), .CENTER_US(CENTER_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_width(cmd_width), .hold(hold), .width_us(width_us),
        .settled(settled), .all_settled(all_settled), .tick_out(tick_out), .cmd_err(cmd_err)
    );

    typedef struct {
        int ch;
        int w;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_cnt, m_ready, m_err;
    int   m_tgt[NUM_CH];
    int   m_wid[NUM_CH];
    int   m_set[NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int clamp_m(input int w);
        if (w < MIN_US) return MIN_US;
        if (w > MAX_US) return MAX_US;
        return w;
    endfunction

    function automatic int step_m(input int w, input int t);
        if (!SLEW) return t;
        if (t - w > STEP_US) return w + STEP_US;
        if (t - w < -STEP_US) return w - STEP_US;
        return t;
    endfunction

    task automatic reset_model();
        m_cnt = 0; m_ready = 0; m_err = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_tgt[c] = CENTER_US; m_wid[c] = CENTER_US; m_set[c] = 1;
        end
        sb_q.delete();
    endtask

    // One clock: advance the model from the inputs now driven, queue expectations, compare after the edge.
    task automatic cycle();
        int   acc, tk, set_all;
        int   n_set[NUM_CH];
        exp_t e;
        logic [NUM_CH-1:0] es;
        acc = (cmd_valid && m_ready != 0) ? 1 : 0;
        tk  = (m_cnt == TICK_DIV - 1) ? 1 : 0;
        for (int c = 0; c < NUM_CH; c++) n_set[c] = (m_wid[c] == m_tgt[c]) ? 1 : 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (tk != 0 && !hold) m_wid[c] = step_m(m_wid[c], m_tgt[c]);
            e.ch = c; e.w = m_wid[c];
            sb_q.push_back(e);
        end
        if (acc != 0 && int'(cmd_chan) < NUM_CH) m_tgt[cmd_chan] = clamp_m(int'(cmd_width));
        m_err   = (acc != 0 && int'(cmd_chan) >= NUM_CH) ? 1 : 0;
        m_cnt   = (m_cnt == TICK_DIV - 1) ? 0 : m_cnt + 1;
        m_ready = 1;
        set_all = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            m_set[c] = n_set[c];
            es[c] = (n_set[c] != 0);
            if (n_set[c] == 0) set_all = 0;
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq($sformatf("width[%0d]", e.ch), 32'(width_us[e.ch]), e.w);
        end
        check_eq("tick_out", 32'(tick_out), (m_cnt == TICK_DIV - 1) ? 1 : 0);
        check_eq("cmd_ready", 32'(cmd_ready), m_ready);
        check_eq("cmd_err", 32'(cmd_err), m_err);
        check_eq("settled", 32'(settled), int'(es));
        check_eq("all_settled", 32'(all_settled), set_all);
    endtask

    task automatic send(input int ch, input int w);
        cmd_valid = 1'b1; cmd_chan = 3'(ch); cmd_width = 16'(w);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        int seen, guard;
        seen = 0; guard = 0;
        while (seen < n && guard < n * TICK_DIV + TICK_DIV) begin
            if (m_cnt == TICK_DIV - 1) seen++;
            cycle();
            guard++;
        end
        check_eq("tick_budget", 32'(seen), n);
    endtask

    task automatic to_tick_cycle();
        int guard;
        guard = 0;
        while (m_cnt != TICK_DIV - 1 && guard < TICK_DIV) begin
            cycle();
            guard++;
        end
        check_eq("tick_align", 32'(m_cnt), TICK_DIV - 1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_chan = 3'd0; cmd_width = 16'd0; hold = 1'b0;
        reset_model();
        #12;
        for (int c = 0; c < NUM_CH; c++) check_eq("rst_width", 32'(width_us[c]), CENTER_US);
        check_eq("rst_settled", 32'(settled), (1 << NUM_CH) - 1);
        check_eq("rst_all_settled", 32'(all_settled), 1);
        check_eq("rst_ready", 32'(cmd_ready), 0);
        check_eq("rst_tick", 32'(tick_out), 0);
        check_eq("rst_err", 32'(cmd_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();
        check_eq("ready_after_release", 32'(cmd_ready), 1);

        // Basic ramp on channel 2
        send(2, 1600);
        run_ticks(1);
        check_eq("ch2_first_tick", 32'(width_us[2]), SLEW ? 1510 : 1600);
        run_ticks(9);
        check_eq("ch2_final", 32'(width_us[2]), 1600);
        check_eq("ch0_untouched", 32'(width_us[0]), 1500);
        cycle();
        check_eq("ch2_settled", 32'(settled[2]), 1);

        // Clamp limits and sub-step move
        send(1, 2500);
        run_ticks(52);
        check_eq("clamp_high", 32'(width_us[1]), 2000);
        send(1, 0);
        run_ticks(102);
        check_eq("clamp_low", 32'(width_us[1]), 1000);
        send(3, 1505);
        run_ticks(1);
        check_eq("small_step", 32'(width_us[3]), 1505);

        // Out-of-range channel
        send(6, 1234);
        check_eq("err_pulse", 32'(cmd_err), 1);
        cycle();
        check_eq("err_clear", 32'(cmd_err), 0);

        // Command coinciding with a tick on a ramping channel
        send(0, 1700);
        run_ticks(3);
        to_tick_cycle();
        cmd_valid = 1'b1; cmd_chan = 3'd0; cmd_width = 16'd1300;
        cycle();
        cmd_valid = 1'b0;
        check_eq("same_edge_old_target", 32'(width_us[0]), SLEW ? 1540 : 1700);
        run_ticks(1);
        check_eq("same_edge_new_target", 32'(width_us[0]), SLEW ? 1530 : 1300);
        run_ticks(30);

        // Hold freezes the ramp while ticks continue
        send(4, 1800);
        run_ticks(5);
        hold = 1'b1;
        run_ticks(3);
        check_eq("hold_frozen", 32'(width_us[4]), SLEW ? 1550 : 1800);
        hold = 1'b0;
        run_ticks(1);
        check_eq("hold_resume", 32'(width_us[4]), SLEW ? 1560 : 1800);

        // Asynchronous reset mid-ramp
        send(4, 1300);
        run_ticks(2);
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_eq("async_width", 32'(width_us[4]), CENTER_US);
        check_eq("async_ready", 32'(cmd_ready), 0);
        check_eq("async_settled", 32'(settled), (1 << NUM_CH) - 1);
        @(posedge clk); #1;
        check_eq("in_reset_width", 32'(width_us[4]), CENTER_US);
        rst_n = 1'b1;
        run_ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
